// File: rtl/rrf_alloc_multi.sv
`timescale 1ns/1ps
// Rename-register (RRF) allocator: grants up to ALLOC_W consecutive tags per cycle,
// reclaims entries on ROB commit and rolls back to a checkpoint on mispredict flush.
module rrf_alloc_multi #(
    parameter int RRF_NUM   = 64,
    parameter int RRF_SEL   = 6,
    parameter int ALLOC_W   = 2,
    parameter int COM_W     = 2,
    parameter int COM_CNT_W = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [ALLOC_W-1:0]         req_en_i,
    input  logic                       stall_dp_i,
    input  logic [COM_CNT_W-1:0]       com_inst_num_i,
    input  logic                       flush_i,
    input  logic [RRF_SEL-1:0]         flush_rrfptr_i,
    input  logic                       flush_rrfcyc_i,
    output logic                       rrf_allocatable_o,
    output logic [RRF_SEL:0]           freenum_o,
    output logic [RRF_SEL-1:0]         rrfptr_o,
    output logic                       rrfcyc_o,
    output logic [ALLOC_W*RRF_SEL-1:0] dst_rrftag_o,
    output logic [ALLOC_W-1:0]         dst_valid_o,
    output logic                       ovf_err_o
);

    localparam int                   SUM_W    = RRF_SEL + 2;
    localparam logic [SUM_W-1:0]     NUM_EXT  = SUM_W'(RRF_NUM);
    localparam logic [RRF_SEL:0]     NUM_FREE = (RRF_SEL + 1)'(RRF_NUM);
    localparam logic [COM_CNT_W-1:0] COM_MAX  = COM_CNT_W'(COM_W);

    // Number of set request bits strictly below lane n.
    function automatic logic [RRF_SEL:0] count_below(input logic [ALLOC_W-1:0] v, input int n);
        logic [RRF_SEL:0] c;
        c = {(RRF_SEL + 1){1'b0}};
        for (int i = 0; i < ALLOC_W; i++) begin
            if (i < n) begin
                c = c + {{RRF_SEL{1'b0}}, v[i]};
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    logic [RRF_SEL-1:0]   rrfptr_r;
    logic                 rrfcyc_r;
    logic [RRF_SEL:0]     freenum_r;
    logic                 ovf_err_r;

    logic [RRF_SEL:0]     reqcnt_s;
    logic                 allocatable_s;
    logic                 fire_s;
    logic [RRF_SEL:0]     alloc_s;
    logic [COM_CNT_W-1:0] com_s;
    logic [RRF_SEL:0]     ptr_sum_s;
    logic [RRF_SEL-1:0]   ptr_diff_s;
    logic [SUM_W-1:0]     squash_s;
    logic [SUM_W-1:0]     free_calc_s;
    logic [RRF_SEL:0]     free_nxt_s;
    logic [RRF_SEL-1:0]   ptr_nxt_s;
    logic                 cyc_nxt_s;
    logic                 ovf_set_s;
    logic [RRF_SEL:0]     lane_off_s [ALLOC_W];

    // Request count, grant decision and allocated amount.
    always_comb begin
        reqcnt_s      = count_below(req_en_i, ALLOC_W);
        allocatable_s = (freenum_r >= reqcnt_s);
        fire_s        = allocatable_s & ~stall_dp_i & ~flush_i;
        if (fire_s) begin
            alloc_s = reqcnt_s;
        end else begin
            alloc_s = {(RRF_SEL + 1){1'b0}};
        end
    end

    // Requesting lanes receive consecutive tags with no holes; tags drive regardless of fire.
    for (genvar g = 0; g < ALLOC_W; g++) begin : g_lane
        assign lane_off_s[g] = count_below(req_en_i, g);
        assign dst_rrftag_o[g*RRF_SEL +: RRF_SEL] = rrfptr_r + lane_off_s[g][RRF_SEL-1:0];
    end

    // Next pointer / free count; a flush reclaims everything allocated past the checkpoint.
    always_comb begin
        if (com_inst_num_i > COM_MAX) begin
            com_s = COM_MAX;
        end else begin
            com_s = com_inst_num_i;
        end
        ptr_sum_s  = {1'b0, rrfptr_r} + alloc_s;
        ptr_diff_s = rrfptr_r - flush_rrfptr_i;
        if (ptr_diff_s == {RRF_SEL{1'b0}}) begin
            if (rrfcyc_r != flush_rrfcyc_i) begin
                squash_s = NUM_EXT;
            end else begin
                squash_s = {SUM_W{1'b0}};
            end
        end else begin
            squash_s = {2'b00, ptr_diff_s};
        end
        if (flush_i) begin
            free_calc_s = {1'b0, freenum_r} + squash_s + SUM_W'(com_s);
            ptr_nxt_s   = flush_rrfptr_i;
            cyc_nxt_s   = flush_rrfcyc_i;
        end else begin
            free_calc_s = {1'b0, freenum_r} - {1'b0, alloc_s} + SUM_W'(com_s);
            ptr_nxt_s   = ptr_sum_s[RRF_SEL-1:0];
            cyc_nxt_s   = rrfcyc_r ^ ptr_sum_s[RRF_SEL];
        end
        if (free_calc_s > NUM_EXT) begin
            free_nxt_s = NUM_FREE;
            ovf_set_s  = 1'b1;
        end else begin
            free_nxt_s = free_calc_s[RRF_SEL:0];
            ovf_set_s  = 1'b0;
        end
    end

    // Allocator state registers; overflow flag is sticky until reset.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rrfptr_r  <= {RRF_SEL{1'b0}};
            rrfcyc_r  <= 1'b0;
            freenum_r <= NUM_FREE;
            ovf_err_r <= 1'b0;
        end else begin
            rrfptr_r  <= ptr_nxt_s;
            rrfcyc_r  <= cyc_nxt_s;
            freenum_r <= free_nxt_s;
            ovf_err_r <= ovf_err_r | ovf_set_s;
        end
    end

    assign rrf_allocatable_o = allocatable_s;
    assign dst_valid_o       = req_en_i & {ALLOC_W{fire_s}};
    assign freenum_o         = freenum_r;
    assign rrfptr_o          = rrfptr_r;
    assign rrfcyc_o          = rrfcyc_r;
    assign ovf_err_o         = ovf_err_r;

endmodule
